// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter that locks one of N requesters per packet onto a registered output beat
module rr_mux_arbiter #(
   parameter int WIDTH = 8,
   parameter int N = 4,
   localparam int SELW = $clog2(N)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N-1:0]       ReqValid,
   input  logic [N*WIDTH-1:0] ReqData,
   input  logic [N-1:0]       ReqLast,
   output logic [N-1:0]       ReqReady,
   output logic               OutValid,
   output logic [WIDTH-1:0]   OutData,
   output logic               OutLast,
   input  logic               OutReady,
   output logic [N-1:0]       Grant,
   output logic [SELW-1:0]    GrantSel
);
   typedef enum logic {IDLE, LOCKED} state_t;
   state_t state;
   logic [SELW-1:0] ptr, winner, idx, ptr_next;
   logic locked, room, accept;
   // descending scan so the candidate closest to ptr is written last and wins
   always_comb begin
      winner = ptr;
      idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = SELW'((int'(ptr) + k) % N);
         if (ReqValid[idx]) winner = idx;
      end
   end
   assign locked   = state == LOCKED;
   assign room     = ~OutValid | OutReady;
   assign ReqReady = locked ? N'(room) << GrantSel : '0;
   assign Grant    = locked ? N'(1) << GrantSel : '0;
   assign accept   = locked & ReqValid[GrantSel] & room;
   assign ptr_next = GrantSel == SELW'(N - 1) ? '0 : GrantSel + SELW'(1);
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         ptr      <= '0;
         GrantSel <= '0;
         OutValid <= 1'b0;
         OutData  <= '0;
         OutLast  <= 1'b0;
      end else begin
         if (!locked && |ReqValid) begin
            GrantSel <= winner;
            state    <= LOCKED;
         end
         if (accept && ReqLast[GrantSel]) begin
            ptr   <= ptr_next;
            state <= IDLE;
         end
         if (accept) begin
            OutData  <= ReqData[int'(GrantSel) * WIDTH +: WIDTH];
            OutLast  <= ReqLast[GrantSel];
            OutValid <= 1'b1;
         end else if (OutValid && OutReady) OutValid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed scenarios with per-requester beat queues and an output scoreboard
module tb_rr_mux_arbiter;
   localparam int WIDTH = 8;
   localparam int N = 4;
   localparam int SELW = $clog2(N);
   logic clk, reset, OutReady, OutValid, OutLast;
   logic [N-1:0] ReqValid, ReqLast, ReqReady, Grant;
   logic [N*WIDTH-1:0] ReqData;
   logic [WIDTH-1:0] OutData;
   logic [SELW-1:0] GrantSel;
   logic [WIDTH:0] src[N][$];
   logic [WIDTH:0] exp_q[$];
   logic [WIDTH:0] e;
   logic [N-1:0] pause;
   logic [N-1:0] g[9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
   int errors = 0, checks = 0;

   rr_mux_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
      .clk(clk), .reset(reset), .ReqValid(ReqValid), .ReqData(ReqData), .ReqLast(ReqLast),
      .ReqReady(ReqReady), .OutValid(OutValid), .OutData(OutData), .OutLast(OutLast),
      .OutReady(OutReady), .Grant(Grant), .GrantSel(GrantSel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic refresh();
      for (int i = 0; i < N; i++) begin
         ReqValid[i] = src[i].size() > 0 && !pause[i];
         {ReqLast[i], ReqData[i*WIDTH +: WIDTH]} = src[i].size() > 0 ? src[i][0] : '0;
      end
   endtask

   task automatic send(input int r, input logic [WIDTH-1:0] d, input logic l, input bit expect_out);
      src[r].push_back({l, d});
      if (expect_out) exp_q.push_back({l, d});
   endtask

   // one clock: score the output beat and note accepted beats before the edge, retire them after
   task automatic step();
      logic [N-1:0] acc;
      @(negedge clk);
      if (reset && OutValid && OutReady) begin
         if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
         else begin
            e = exp_q.pop_front();
            check("sb_beat", {OutLast, OutData}, e);
         end
      end
      acc = ReqValid & ReqReady;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (acc[i]) void'(src[i].pop_front());
      refresh();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      OutReady = 1'b1;
      pause = '0;
      send(0, 8'h10, 1'b1, 1'b1);
      send(1, 8'h11, 1'b1, 1'b1);
      send(2, 8'h12, 1'b1, 1'b1);
      send(3, 8'h13, 1'b1, 1'b1);
      send(0, 8'h14, 1'b1, 1'b1);
      refresh();
      repeat (3) begin
         step();
         check("rst_grant", Grant, 0);
         check("rst_ready", ReqReady, 0);
         check("rst_valid", OutValid, 0);
      end
      reset = 1'b1;
      for (int k = 0; k < 9; k++) begin
         step();
         if (k == 0) check("first_sel", GrantSel, 0);
         check("rr_grant", Grant, g[k]);
      end
      repeat (3) step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      send(0, 8'hA5, 1'b1, 1'b1);
      refresh();
      step();
      check("sb_sel", GrantSel, 0);
      check("sb_ready", ReqReady, 4'b0001);
      step();
      check("sb_valid", OutValid, 1);
      check("sb_data", OutData, 8'hA5);
      check("sb_last", OutLast, 1);
      check("sb_idle", Grant, 0);
      send(0, 8'h30, 1'b1, 1'b0);
      send(1, 8'h31, 1'b1, 1'b1);
      exp_q.push_back({1'b1, 8'h30});
      refresh();
      step();
      check("ptr1_sel", GrantSel, 1);
      repeat (4) step();
      send(2, 8'h40, 1'b0, 1'b1);
      send(2, 8'h41, 1'b0, 1'b1);
      send(2, 8'h42, 1'b1, 1'b1);
      refresh();
      repeat (3) step();
      OutReady = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_ready", ReqReady, 0);
         check("bp_data", OutData, 8'h41);
         step();
      end
      OutReady = 1'b1;
      repeat (4) step();
      send(3, 8'h50, 1'b0, 1'b1);
      send(3, 8'h51, 1'b0, 1'b1);
      send(3, 8'h52, 1'b1, 1'b1);
      send(1, 8'h60, 1'b1, 1'b1);
      refresh();
      step();
      check("hw_owner", GrantSel, 3);
      step();
      pause[3] = 1'b1;
      refresh();
      for (int k = 0; k < 4; k++) begin
         check("hw_hold", Grant, 4'b1000);
         check("hw_ready1", ReqReady[1], 0);
         step();
      end
      pause[3] = 1'b0;
      refresh();
      repeat (3) step();
      check("hw_sel", GrantSel, 1);
      check("hw_grant", Grant, 4'b0010);
      repeat (4) step();
      send(0, 8'h70, 1'b0, 1'b1);
      send(0, 8'h71, 1'b0, 1'b0);
      send(0, 8'h72, 1'b0, 1'b0);
      send(0, 8'h73, 1'b1, 1'b0);
      refresh();
      step();
      check("rm_owner", GrantSel, 0);
      step();
      step();
      check("rm_beat", OutData, 8'h71);
      reset = 1'b0;
      step();
      check("rm_valid", OutValid, 0);
      check("rm_grant", Grant, 0);
      check("rm_ready", ReqReady, 0);
      src[0].delete();
      reset = 1'b1;
      send(1, 8'h80, 1'b1, 1'b1);
      send(3, 8'h81, 1'b1, 1'b1);
      refresh();
      step();
      check("rm_sel", GrantSel, 1);
      repeat (6) step();
      check("sb_left", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
